// File: rtl/twiddle_fold8_gen.sv
// Twiddle-factor generator for one R2^2 SDF stage: counts samples, folds the twiddle index
// onto a 1/8-size cos/sin ROM and unfolds the returned data to exp(-j2*pi*n/N).
module twiddle_fold8_gen #(
    parameter int unsigned LOG_N   = 6,
    parameter int unsigned WIDTH   = 16,
    parameter int unsigned ROM_LAT = 1,
    parameter int unsigned TC_FF   = 1
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             in_en,
    input  logic             inv,
    output logic             rom_en,
    output logic [LOG_N-4:0] rom_addr,
    input  logic [WIDTH-1:0] rom_re,
    input  logic [WIDTH-1:0] rom_im,
    output logic             tw_en,
    output logic             tw_first,
    output logic             tw_unity,
    output logic [WIDTH-1:0] tw_re,
    output logic [WIDTH-1:0] tw_im
);

    localparam int unsigned RW = LOG_N - 3;
    localparam logic [WIDTH-1:0] MinVal = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [WIDTH-1:0] MaxVal = ~MinVal;
    localparam real CosPi4 = 0.7071067811865476;
    localparam int CosMqInt = int'(CosPi4 * (2.0 ** (WIDTH - 1)));
    localparam logic [WIDTH-1:0] CosMq = WIDTH'(CosMqInt);

    // ---------------- sample counter and twiddle index ----------------
    logic [LOG_N-1:0] cnt_q;
    logic             frm_inv_q;
    logic [LOG_N-1:0] kx;
    logic [LOG_N-1:0] n_d;
    logic             first_d;
    logic             s1_inv_d;

    always_comb begin
        kx       = {2'b00, cnt_q[LOG_N-3:0]};
        first_d  = (cnt_q == '0);
        // The m==0 sample already uses the inv value being captured for its frame.
        s1_inv_d = first_d ? inv : frm_inv_q;
        unique case (cnt_q[LOG_N-1 -: 2])
            2'd0:    n_d = '0;
            2'd1:    n_d = kx << 1;
            2'd2:    n_d = kx;
            default: n_d = kx + (kx << 1);
        endcase
    end

    logic [LOG_N-1:0] s1_n_q;
    logic             s1_vld_q;
    logic             s1_first_q;
    logic             s1_inv_q;

    always_ff @(posedge clock) begin
        if (reset) begin
            cnt_q      <= '0;
            frm_inv_q  <= 1'b0;
            s1_n_q     <= '0;
            s1_vld_q   <= 1'b0;
            s1_first_q <= 1'b0;
            s1_inv_q   <= 1'b0;
        end else begin
            s1_vld_q   <= in_en;
            s1_first_q <= in_en & first_d;
            if (in_en) begin
                cnt_q    <= cnt_q + LOG_N'(1);
                s1_n_q   <= n_d;
                s1_inv_q <= s1_inv_d;
                if (first_d) begin
                    frm_inv_q <= inv;
                end
            end
        end
    end

    // ---------------- fold onto the 1/8 ROM ----------------
    logic [2:0]    s1_o;
    logic [RW-1:0] s1_r;
    logic [RW-1:0] s1_r_neg;
    logic          s1_rz;

    always_comb begin
        s1_o     = s1_n_q[LOG_N-1 -: 3];
        s1_r     = s1_n_q[RW-1:0];
        s1_r_neg = RW'(0) - s1_r;
        s1_rz    = (s1_r == '0);
        rom_en   = s1_vld_q;
        rom_addr = s1_o[0] ? s1_r_neg : s1_r;
    end

    // ---------------- delay line aligned with ROM data ----------------
    logic [2:0] dl_o_q     [ROM_LAT];
    logic       dl_rz_q    [ROM_LAT];
    logic       dl_vld_q   [ROM_LAT];
    logic       dl_first_q [ROM_LAT];
    logic       dl_inv_q   [ROM_LAT];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < ROM_LAT; i++) begin
                dl_o_q[i]     <= '0;
                dl_rz_q[i]    <= 1'b0;
                dl_vld_q[i]   <= 1'b0;
                dl_first_q[i] <= 1'b0;
                dl_inv_q[i]   <= 1'b0;
            end
        end else begin
            dl_o_q[0]     <= s1_o;
            dl_rz_q[0]    <= s1_rz;
            dl_vld_q[0]   <= s1_vld_q;
            dl_first_q[0] <= s1_first_q;
            dl_inv_q[0]   <= s1_inv_q;
            for (int i = 1; i < ROM_LAT; i++) begin
                dl_o_q[i]     <= dl_o_q[i-1];
                dl_rz_q[i]    <= dl_rz_q[i-1];
                dl_vld_q[i]   <= dl_vld_q[i-1];
                dl_first_q[i] <= dl_first_q[i-1];
                dl_inv_q[i]   <= dl_inv_q[i-1];
            end
        end
    end

    // ---------------- unfold ----------------
    logic [2:0]       s2_o;
    logic             s2_rz;
    logic             s2_vld;
    logic             s2_first;
    logic             s2_inv;
    logic [WIDTH-1:0] neg_a;
    logic [WIDTH-1:0] neg_b;
    logic [WIDTH-1:0] neg_c;
    logic [WIDTH-1:0] unf_re;
    logic [WIDTH-1:0] unf_im;
    logic [WIDTH-1:0] out_im;
    logic             unf_unity;

    always_comb begin
        s2_o      = dl_o_q[ROM_LAT-1];
        s2_rz     = dl_rz_q[ROM_LAT-1];
        s2_vld    = dl_vld_q[ROM_LAT-1];
        s2_first  = dl_first_q[ROM_LAT-1];
        s2_inv    = dl_inv_q[ROM_LAT-1];
        neg_a     = WIDTH'(0) - rom_re;
        neg_b     = WIDTH'(0) - rom_im;
        neg_c     = WIDTH'(0) - CosMq;
        unf_re    = '0;
        unf_im    = '0;
        unf_unity = 1'b0;
        if (s2_rz) begin
            // Octant boundaries are exact constants; ROM data is ignored.
            case (s2_o)
                3'd0: unf_unity = 1'b1;
                3'd1: begin unf_re = CosMq;  unf_im = neg_c;  end
                3'd2: begin unf_re = '0;     unf_im = MinVal; end
                3'd3: begin unf_re = neg_c;  unf_im = neg_c;  end
                default: begin unf_re = '0;  unf_im = '0;     end
            endcase
        end else begin
            case (s2_o)
                3'd0: begin unf_re = rom_re; unf_im = rom_im; end
                3'd1: begin unf_re = neg_b;  unf_im = neg_a;  end
                3'd2: begin unf_re = rom_im; unf_im = neg_a;  end
                3'd3: begin unf_re = neg_a;  unf_im = rom_im; end
                3'd4: begin unf_re = neg_a;  unf_im = neg_b;  end
                3'd5: begin unf_re = rom_im; unf_im = rom_re; end
                default: begin unf_re = rom_re; unf_im = rom_im; end
            endcase
        end
        if (s2_inv) begin
            out_im = (unf_im == MinVal) ? MaxVal : (WIDTH'(0) - unf_im);
        end else begin
            out_im = unf_im;
        end
    end

    // ---------------- output stage ----------------
    if (TC_FF != 0) begin : g_out_reg
        logic             tw_en_q;
        logic             tw_first_q;
        logic             tw_unity_q;
        logic [WIDTH-1:0] tw_re_q;
        logic [WIDTH-1:0] tw_im_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                tw_en_q    <= 1'b0;
                tw_first_q <= 1'b0;
                tw_unity_q <= 1'b0;
                tw_re_q    <= '0;
                tw_im_q    <= '0;
            end else begin
                tw_en_q    <= s2_vld;
                tw_first_q <= s2_vld & s2_first;
                tw_unity_q <= s2_vld & unf_unity;
                if (s2_vld) begin
                    tw_re_q <= unf_re;
                    tw_im_q <= out_im;
                end
            end
        end

        assign tw_en    = tw_en_q;
        assign tw_first = tw_first_q;
        assign tw_unity = tw_unity_q;
        assign tw_re    = tw_re_q;
        assign tw_im    = tw_im_q;
    end else begin : g_out_comb
        // Last valid value is kept so idle cycles still present a stable coefficient.
        logic [WIDTH-1:0] hold_re_q;
        logic [WIDTH-1:0] hold_im_q;

        always_ff @(posedge clock) begin
            if (reset) begin
                hold_re_q <= '0;
                hold_im_q <= '0;
            end else if (s2_vld) begin
                hold_re_q <= unf_re;
                hold_im_q <= out_im;
            end
        end

        assign tw_en    = s2_vld;
        assign tw_first = s2_vld & s2_first;
        assign tw_unity = s2_vld & unf_unity;
        assign tw_re    = s2_vld ? unf_re : hold_re_q;
        assign tw_im    = s2_vld ? out_im : hold_im_q;
    end

endmodule

// File: tb/tb_twiddle_fold8_gen.sv
// Directed bench for twiddle_fold8_gen (N=64, 16-bit, ROM_LAT=1, registered output).
module tb_twiddle_fold8_gen;

    localparam real Pi = 3.141592653589793;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_en;
    logic        inv;
    logic        rom_en;
    logic [2:0]  rom_addr;
    logic [15:0] rom_re;
    logic [15:0] rom_im;
    logic        tw_en;
    logic        tw_first;
    logic        tw_unity;
    logic [15:0] tw_re;
    logic [15:0] tw_im;

    twiddle_fold8_gen #(
        .LOG_N  (6),
        .WIDTH  (16),
        .ROM_LAT(1),
        .TC_FF  (1)
    ) dut (
        .clock   (clock),
        .reset   (reset),
        .in_en   (in_en),
        .inv     (inv),
        .rom_en  (rom_en),
        .rom_addr(rom_addr),
        .rom_re  (rom_re),
        .rom_im  (rom_im),
        .tw_en   (tw_en),
        .tw_first(tw_first),
        .tw_unity(tw_unity),
        .tw_re   (tw_re),
        .tw_im   (tw_im)
    );

    always #5 clock = ~clock;

    // Behavioural 1-cycle ROM; entry 0 holds junk so r==0 outputs prove ROM independence.
    logic [15:0] rom_re_tab [8];
    logic [15:0] rom_im_tab [8];
    always @(posedge clock) begin
        rom_re <= rom_re_tab[rom_addr];
        rom_im <= rom_im_tab[rom_addr];
    end

    typedef struct {
        bit          vld;
        bit          first;
        bit          unity;
        logic [15:0] re;
        logic [15:0] im;
        int          m;
        bit          iv;
    } exp_t;

    exp_t        pipe[$];
    int          checks = 0;
    int          errors = 0;
    int          tb_cnt = 0;
    bit          tb_inv = 1'b0;
    logic [15:0] last_re = '0;
    logic [15:0] last_im = '0;

    function automatic int rnd(input real x);
        if (x >= 0.0) return $rtoi(x + 0.5);
        return -$rtoi(0.5 - x);
    endfunction

    function automatic int n_of(input int m);
        int mult[4] = '{0, 2, 1, 3};
        return ((m % 16) * mult[m / 16]) % 64;
    endfunction

    function automatic exp_t model(input int m, input bit iv);
        exp_t e;
        int   n;
        n       = n_of(m);
        e.vld   = 1'b1;
        e.first = (m == 0);
        e.m     = m;
        e.iv    = iv;
        if (n == 0) begin
            e.unity = 1'b1;
            e.re    = '0;
            e.im    = '0;
        end else begin
            e.unity = 1'b0;
            e.re    = 16'(rnd(32768.0 * $cos(2.0 * Pi * n / 64.0)));
            e.im    = 16'(rnd(-32768.0 * $sin(2.0 * Pi * n / 64.0)));
        end
        if (iv) e.im = (e.im == 16'h8000) ? 16'h7FFF : (16'h0 - e.im);
        return e;
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, expv);
            $error("check %s", tag);
        end
    endtask

    task automatic compare(input exp_t e);
        check($sformatf("tw_en m=%0d", e.m), tw_en, e.vld);
        check($sformatf("tw_first m=%0d", e.m), tw_first, e.vld & e.first);
        check($sformatf("tw_unity m=%0d", e.m), tw_unity, e.vld & e.unity);
        if (e.vld) begin
            last_re = e.re;
            last_im = e.im;
        end
        check($sformatf("tw_re m=%0d", e.m), tw_re, last_re);
        check($sformatf("tw_im m=%0d", e.m), tw_im, last_im);
        if (e.vld) begin
            case (e.m)
                17: begin
                    check("m17 re", tw_re, rom_re_tab[2]);
                    check("m17 im", tw_im, e.iv ? 16'(16'h0 - rom_im_tab[2]) : rom_im_tab[2]);
                end
                24: begin
                    check("m24 re", tw_re, 16'h0000);
                    check("m24 im", tw_im, e.iv ? 16'h7FFF : 16'h8000);
                end
                40: begin
                    check("m40 re", tw_re, 16'h5A82);
                    check("m40 im", tw_im, e.iv ? 16'h5A82 : 16'hA57E);
                end
                56: begin
                    check("m56 re", tw_re, 16'hA57E);
                    check("m56 im", tw_im, e.iv ? 16'h5A82 : 16'hA57E);
                end
                63: begin
                    check("m63 re", tw_re, rom_im_tab[3]);
                    check("m63 im", tw_im, e.iv ? 16'(16'h0 - rom_re_tab[3]) : rom_re_tab[3]);
                end
                default: ;
            endcase
        end
    endtask

    task automatic step(input bit en, input bit iv);
        exp_t e;
        int   n;
        int   addr_exp;
        e        = '{default: 0};
        addr_exp = 0;
        in_en    = en;
        inv      = iv;
        if (en) begin
            if (tb_cnt == 0) tb_inv = iv;
            e        = model(tb_cnt, tb_inv);
            n        = n_of(tb_cnt);
            addr_exp = ((n / 8) % 2 == 1) ? ((8 - (n % 8)) % 8) : (n % 8);
            tb_cnt   = (tb_cnt + 1) % 64;
        end
        pipe.push_back(e);
        @(posedge clock);
        #1;
        check("rom_en", rom_en, en);
        if (en) check($sformatf("rom_addr m=%0d", e.m), rom_addr, addr_exp);
        compare(pipe.pop_front());
    endtask

    task automatic do_reset(input int cycles);
        exp_t idle;
        idle  = '{default: 0};
        reset = 1'b1;
        in_en = 1'b1;
        inv   = 1'b1;
        repeat (cycles) @(posedge clock);
        #1;
        reset = 1'b0;
        in_en = 1'b0;
        inv   = 1'b0;
        check("rst tw_en", tw_en, 1'b0);
        check("rst tw_first", tw_first, 1'b0);
        check("rst tw_unity", tw_unity, 1'b0);
        check("rst tw_re", tw_re, 16'h0);
        check("rst tw_im", tw_im, 16'h0);
        check("rst rom_en", rom_en, 1'b0);
        pipe.delete();
        pipe.push_back(idle);
        pipe.push_back(idle);
        tb_cnt  = 0;
        tb_inv  = 1'b0;
        last_re = '0;
        last_im = '0;
    endtask

    initial begin
        int acc;
        int guard;
        reset = 1'b1;
        in_en = 1'b0;
        inv   = 1'b0;
        rom_re_tab[0] = 16'h1357;
        rom_im_tab[0] = 16'h2468;
        for (int i = 1; i < 8; i++) begin
            rom_re_tab[i] = 16'(rnd(32768.0 * $cos(2.0 * Pi * i / 64.0)));
            rom_im_tab[i] = 16'(rnd(-32768.0 * $sin(2.0 * Pi * i / 64.0)));
        end

        do_reset(2);
        step(1'b0, 1'b0);
        step(1'b0, 1'b0);

        // Forward frame; inv raised at m=30 must be ignored.
        for (int m = 0; m < 64; m++) step(1'b1, m >= 30);
        // Inverse frame; inv dropped at m=30 must be ignored.
        for (int m = 0; m < 64; m++) step(1'b1, m < 30);

        // Two forward frames with random bubbles.
        acc   = 0;
        guard = 0;
        while (acc < 128 && guard < 2000) begin
            bit en;
            en = ($urandom_range(0, 9) >= 4);
            step(en, 1'b0);
            if (en) acc++;
            guard++;
        end
        check("bubble frames completed", acc, 128);
        repeat (4) step(1'b0, 1'b0);

        // Reset at m=20 with in_en high; restart must begin at m=0.
        for (int m = 0; m < 20; m++) step(1'b1, 1'b0);
        do_reset(1);
        for (int m = 0; m < 6; m++) step(1'b1, 1'b0);
        repeat (4) step(1'b0, 1'b0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
